task_mem_loader: RTL and testbench
==================================

// Module: task_mem_loader
// PURPOSE
//  Upstream feeder of the Task Scheduler. Receives a task program from the host as a stream of words.
//  Packs the words into TM frames in a shadow buffer while the active buffer drives the scheduler's
//  flat env_task_memory bus. Swaps shadow -> active only on a VGA frame boundary (vga_en pulse), so
//  the scheduler never sees a half-written program.
// PARAMETERS
//  WORD_W     32                 host word width, bits
//  FRAME_W    `TM_WIDTH          bits per TM frame
//  DEPTH      `TASK_MEM_DEPTH    frames per buffer
//  localparam WPF = ceil(FRAME_W/WORD_W)   words per frame
//  localparam CAP = DEPTH*WPF               words per buffer
// PORTS
//  clk              in   1              system clock
//  reset_n          in   1              asynchronous reset, active low
//  wr_valid         in   1              host word valid
//  wr_ready         out  1              loader accepts word; transfer on wr_valid & wr_ready
//  wr_data          in   WORD_W         host word
//  wr_last          in   1              qualifies the final word of a program
//  vga_en           in   1              Task Scheduler frame-boundary pulse; swap point
//  env_task_memory  out  DEPTH*FRAME_W  active buffer; frame f at [f*FRAME_W +: FRAME_W]
//  load_busy        out  1              FILL in progress
//  swap_pending     out  1              complete program waiting for vga_en
//  prog_valid       out  1              active buffer holds a host-loaded program (sticky)
//  err_overflow     out  1              sticky: more than CAP words in the current load
// BEHAVIOUR
//  - Reset (async, reset_n=0): both buffers all-zero (zero frame = idle control frame for the scheduler).
//    State=IDLE, counter=0, wr_ready=1, all status outputs 0.
//  - Packing: word n of a load -> frame n/WPF, bits [(n%WPF)*WORD_W +: WORD_W].
//    Bits at or above FRAME_W are truncated. Counter width = clog2(CAP+1).
//  - FSM:
//    IDLE: first accepted word clears the whole shadow buffer (same cycle) and clears err_overflow.
//      It writes word 0, counter=1, -> FILL; if that word carries wr_last, -> PEND.
//    FILL: each accepted word is written at the counter, counter+1.
//      At counter==CAP, further words are accepted and dropped, and err_overflow is set.
//      Accepted word with wr_last -> PEND. Frames not written keep zero (partial frame zero-filled).
//    PEND: wr_ready=0; swap_pending=1. On vga_en=1: active<=shadow in one cycle, prog_valid<=1,
//      counter<=0 -> IDLE.
//      env_task_memory changes exactly 1 cycle after the vga_en sample.
//  - wr_ready = (state!=PEND). load_busy = (state==FILL). swap_pending = (state==PEND).
//  - wr_last and vga_en in the same cycle (FILL): enter PEND. The swap waits for the next vga_en,
//    never the same one.
//  - vga_en in IDLE/FILL: no effect. Active buffer never changes except on a PEND swap.
//  - Reset mid-FILL or mid-PEND: the load is discarded and the active buffer is zeroed (scheduler restarts idle).
//  - No combinational path wr_valid -> wr_ready. env_task_memory is driven from flops only.
// STRUCTURE
//  - Shared include (SharedInc/Ranges.def.v): `TM_WIDTH, `TASK_MEM_DEPTH, `ENV_TASK_MEMORY_RANGE(i),
//    new `HOST_WORD_W and `TML_STATE_* encodings (IDLE=2'd0, FILL=2'd1, PEND=2'd2).
//  - One sub-module: tm_shadow_buf. Holds the DEPTH x FRAME_W shadow store, with clear, word-write
//    (frame index, word index, data) and full-buffer read ports.
//  - The FSM, counter and active buffer stay in task_mem_loader.
// TESTING  (WORD_W=32, FRAME_W=80, WPF=3, DEPTH=4, CAP=12)
//  1. Reset, then no stimulus -> env_task_memory==0, wr_ready=1, prog_valid=0 for 100 cycles.
//     Pulse vga_en -> bus unchanged.
//  2. Load 12 words 0x1..0xC, last on 0xC -> swap_pending=1, wr_ready=0. vga_en pulse ->
//     the next cycle frame0 = {16'h0003 (word 0x3 truncated), 32'h2, 32'h1} and prog_valid=1.
//  3. Load 4 words with wr_last on word 4 -> frame1 holds word 4 in bits[31:0].
//     Frames 2..3 are zero after the swap, and earlier contents are gone.
//  4. Load 14 words -> err_overflow=1 after word 13; words 13..14 dropped; frames 0..3 hold words 1..12.
//     A new load clears err_overflow.
//  5. wr_last coincident with vga_en -> no swap that cycle. Swap on the following vga_en only.
//     During PEND, wr_valid held high -> no word accepted.
//  6. Assert reset_n=0 mid-FILL (word 5) and mid-PEND -> outputs go to reset values immediately
//     (asynchronously); bus=0; the next load starts at frame 0.

Source files
------------

// File: rtl/task_mem_loader_pkg.sv
// Shared sizes, state encoding and small sizing helpers for the task memory loader.
// Default geometry matches the Task Scheduler's TM frame layout.
package task_mem_loader_pkg;

   localparam int TM_WIDTH       = 80;
   localparam int TASK_MEM_DEPTH = 4;
   localparam int HOST_WORD_W    = 32;

   typedef enum logic [1:0] {
      TML_STATE_IDLE = 2'd0,
      TML_STATE_FILL = 2'd1,
      TML_STATE_PEND = 2'd2
   } tml_state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Index width that stays legal (>= 1 bit) for single-entry dimensions.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tm_shadow_buf.sv
// Shadow frame store: DEPTH frames of FRAME_W bits written one host word at a time.
// A clear and a write in the same cycle leave only the written word non-zero.
module tm_shadow_buf
   import task_mem_loader_pkg::*;
#(
   parameter int WORD_W  = HOST_WORD_W,
   parameter int FRAME_W = TM_WIDTH,
   parameter int DEPTH   = TASK_MEM_DEPTH,
   localparam int WPF    = ceil_div(FRAME_W, WORD_W),
   localparam int FIW    = idx_w(DEPTH),
   localparam int WIW    = idx_w(WPF)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [FIW-1:0]           frame_idx,
   input  logic [WIW-1:0]           word_idx,
   input  logic [WORD_W-1:0]        wr_data,
   output logic [DEPTH*FRAME_W-1:0] rd_data
);

   genvar gi, gw;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_frame
         for (gw = 0; gw < WPF; gw++) begin : g_word
            // The top word of a frame is narrower; its excess host bits are simply not stored.
            localparam int LO = gw * WORD_W;
            localparam int FW = ((FRAME_W - LO) < WORD_W) ? (FRAME_W - LO) : WORD_W;

            logic [FW-1:0] field_reg;
            logic          hit;

            assign hit = wr_en && (frame_idx == FIW'(gi)) && (word_idx == WIW'(gw));

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n)
                  field_reg <= '0;
               else if (hit)
                  field_reg <= wr_data[FW-1:0];
               else if (clr)
                  field_reg <= '0;
            end

            assign rd_data[gi*FRAME_W + LO +: FW] = field_reg;
         end
      end
   endgenerate

endmodule

// File: rtl/task_mem_loader.sv
// Packs a host word stream into TM frames in a shadow buffer and swaps it into the
// scheduler-facing active buffer only on a vga_en frame boundary.
module task_mem_loader
   import task_mem_loader_pkg::*;
#(
   parameter int WORD_W  = HOST_WORD_W,
   parameter int FRAME_W = TM_WIDTH,
   parameter int DEPTH   = TASK_MEM_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [WORD_W-1:0]        wr_data,
   input  logic                     wr_last,
   input  logic                     vga_en,
   output logic [DEPTH*FRAME_W-1:0] env_task_memory,
   output logic                     load_busy,
   output logic                     swap_pending,
   output logic                     prog_valid,
   output logic                     err_overflow
);

   localparam int WPF = ceil_div(FRAME_W, WORD_W);
   localparam int CAP = DEPTH * WPF;
   localparam int CW  = $clog2(CAP + 1);
   localparam int FIW = idx_w(DEPTH);
   localparam int WIW = idx_w(WPF);

   tml_state_t               state_reg, state_next;
   logic [CW-1:0]            count_reg, count_next;
   logic [FIW-1:0]           frame_reg, frame_next, adv_frame;
   logic [WIW-1:0]           word_reg, word_next, adv_word;
   logic                     err_reg, err_next;
   logic                     prog_valid_reg;
   logic [DEPTH*FRAME_W-1:0] active_reg;
   logic [DEPTH*FRAME_W-1:0] shadow_data;
   logic                     accept, buf_clr, buf_wr, do_swap;

   assign accept = wr_valid && wr_ready;

   // Write position after the current one; IDLE always holds position (0,0).
   assign adv_word  = (word_reg == WIW'(WPF - 1)) ? '0 : word_reg + WIW'(1);
   assign adv_frame = (word_reg == WIW'(WPF - 1)) ? frame_reg + FIW'(1) : frame_reg;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      frame_next = frame_reg;
      word_next  = word_reg;
      err_next   = err_reg;
      buf_clr    = 1'b0;
      buf_wr     = 1'b0;
      do_swap    = 1'b0;
      case (state_reg)
         TML_STATE_IDLE: begin
            if (accept) begin
               buf_clr    = 1'b1;
               buf_wr     = 1'b1;
               err_next   = 1'b0;
               count_next = CW'(1);
               frame_next = adv_frame;
               word_next  = adv_word;
               state_next = wr_last ? TML_STATE_PEND : TML_STATE_FILL;
            end
         end
         TML_STATE_FILL: begin
            if (accept) begin
               if (count_reg == CW'(CAP)) begin
                  err_next = 1'b1;
               end else begin
                  buf_wr     = 1'b1;
                  count_next = count_reg + CW'(1);
                  frame_next = adv_frame;
                  word_next  = adv_word;
               end
               if (wr_last)
                  state_next = TML_STATE_PEND;
            end
         end
         TML_STATE_PEND: begin
            if (vga_en) begin
               do_swap    = 1'b1;
               count_next = '0;
               frame_next = '0;
               word_next  = '0;
               state_next = TML_STATE_IDLE;
            end
         end
         default: state_next = TML_STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= TML_STATE_IDLE;
         count_reg      <= '0;
         frame_reg      <= '0;
         word_reg       <= '0;
         err_reg        <= 1'b0;
         prog_valid_reg <= 1'b0;
         active_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         frame_reg      <= frame_next;
         word_reg       <= word_next;
         err_reg        <= err_next;
         prog_valid_reg <= prog_valid_reg | do_swap;
         if (do_swap)
            active_reg <= shadow_data;
      end
   end

   tm_shadow_buf #(
      .WORD_W  (WORD_W),
      .FRAME_W (FRAME_W),
      .DEPTH   (DEPTH)
   ) u_shadow (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (buf_clr),
      .wr_en     (buf_wr),
      .frame_idx (frame_reg),
      .word_idx  (word_reg),
      .wr_data   (wr_data),
      .rd_data   (shadow_data)
   );

   assign wr_ready        = (state_reg != TML_STATE_PEND);
   assign load_busy       = (state_reg == TML_STATE_FILL);
   assign swap_pending    = (state_reg == TML_STATE_PEND);
   assign prog_valid      = prog_valid_reg;
   assign err_overflow    = err_reg;
   assign env_task_memory = active_reg;

endmodule

// File: tb/tb_task_mem_loader.sv
// Scoreboard bench for task_mem_loader: each load pushes its expected active bus,
// each vga_en swap pops and compares it against env_task_memory.
module tb_task_mem_loader;
   import task_mem_loader_pkg::*;

   localparam int WORD_W  = 32;
   localparam int FRAME_W = 80;
   localparam int DEPTH   = 4;
   localparam int WPF     = 3;
   localparam int CAP     = 12;
   localparam int BUS_W   = DEPTH * FRAME_W;

   logic              clk      = 1'b0;
   logic              reset_n  = 1'b0;
   logic              wr_valid = 1'b0;
   logic              wr_last  = 1'b0;
   logic              vga_en   = 1'b0;
   logic [WORD_W-1:0] wr_data  = '0;
   logic              wr_ready, load_busy, swap_pending, prog_valid, err_overflow;
   logic [BUS_W-1:0]  env_task_memory;

   int               vectors     = 0;
   int               miscompares = 0;
   logic [BUS_W-1:0] exp_q[$];
   logic [BUS_W-1:0] cur_bus = '0;

   always #5 clk = ~clk;

   task_mem_loader #(
      .WORD_W  (WORD_W),
      .FRAME_W (FRAME_W),
      .DEPTH   (DEPTH)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_data         (wr_data),
      .wr_last         (wr_last),
      .vga_en          (vga_en),
      .env_task_memory (env_task_memory),
      .load_busy       (load_busy),
      .swap_pending    (swap_pending),
      .prog_valid      (prog_valid),
      .err_overflow    (err_overflow)
   );

   // Word k of a load is base + k*step; only the first CAP words land, truncated to the frame.
   function automatic logic [BUS_W-1:0] model_bus(input int n, input logic [31:0] base,
                                                  input logic [31:0] step);
      logic [BUS_W-1:0] b;
      logic [31:0]      w;
      b = '0;
      for (int k = 0; k < n && k < CAP; k++) begin
         w = base + step * k;
         for (int bi = 0; bi < WORD_W; bi++) begin
            int pos;
            pos = (k % WPF) * WORD_W + bi;
            if (pos < FRAME_W)
               b[(k / WPF) * FRAME_W + pos] = w[bi];
         end
      end
      return b;
   endfunction

   task automatic send_word(input logic [31:0] d, input logic last, input logic vga);
      int waited;
      waited = 0;
      while (wr_ready !== 1'b1 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (waited >= 50) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: wr_ready=%b required 1", wr_ready);
      end
      wr_valid = 1'b1; wr_data = d; wr_last = last; vga_en = vga;
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_last = 1'b0; vga_en = 1'b0;
      $display("word %h last=%b vga_en=%b", d, last, vga);
   endtask

   task automatic load_program(input int n, input logic [31:0] base, input logic [31:0] step,
                               input logic with_last, input logic push);
      if (push) exp_q.push_back(model_bus(n, base, step));
      for (int k = 0; k < n; k++)
         send_word(base + step * k, with_last && (k == n - 1), 1'b0);
   endtask

   task automatic pulse_swap(input string name);
      logic [BUS_W-1:0] exp_bus;
      vectors++;
      if (env_task_memory !== cur_bus) begin
         miscompares++;
         $display("FAIL %s_pre: bus=%h required %h", name, env_task_memory, cur_bus);
      end
      vga_en = 1'b1;
      @(posedge clk); #1;
      vga_en = 1'b0;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s_queue: no expected program queued", name);
      end else begin
         exp_bus = exp_q.pop_front();
         $display("swap %s bus=%h", name, env_task_memory);
         if (env_task_memory !== exp_bus) begin
            miscompares++;
            $display("FAIL %s_bus: bus=%h required %h", name, env_task_memory, exp_bus);
         end
         cur_bus = exp_bus;
      end
      vectors++;
      if ({prog_valid, swap_pending, wr_ready} !== 3'b101) begin
         miscompares++;
         $display("FAIL %s_status: {pv,pend,rdy}=%b required 101", name,
                  {prog_valid, swap_pending, wr_ready});
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (env_task_memory !== '0 || wr_ready !== 1'b1 || prog_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d: bus=%h rdy=%b pv=%b required 0/1/0",
                     i, env_task_memory, wr_ready, prog_valid);
         end
      end
      vectors++;
      if ({load_busy, swap_pending, err_overflow} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_status: {busy,pend,err}=%b required 000",
                  {load_busy, swap_pending, err_overflow});
      end
      vga_en = 1'b1;
      @(posedge clk); #1;
      vga_en = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (env_task_memory !== '0 || prog_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_vga: bus=%h pv=%b required 0/0", env_task_memory, prog_valid);
      end
   endtask

   task automatic test_full_load();
      load_program(12, 32'h1, 32'h1, 1'b1, 1'b1);
      vectors++;
      if ({swap_pending, wr_ready, load_busy} !== 3'b100) begin
         miscompares++;
         $display("FAIL full_pend: {pend,rdy,busy}=%b required 100",
                  {swap_pending, wr_ready, load_busy});
      end
      pulse_swap("full_load");
      vectors++;
      if (env_task_memory[79:0] !== {16'h0003, 32'h2, 32'h1}) begin
         miscompares++;
         $display("FAIL full_frame0: got %h required %h", env_task_memory[79:0],
                  {16'h0003, 32'h2, 32'h1});
      end
   endtask

   task automatic test_partial();
      load_program(4, 32'h11, 32'h11, 1'b1, 1'b1);
      pulse_swap("partial");
      vectors++;
      if (env_task_memory[FRAME_W +: 32] !== 32'h44) begin
         miscompares++;
         $display("FAIL partial_frame1: got %h required 00000044", env_task_memory[FRAME_W +: 32]);
      end
      vectors++;
      if (env_task_memory[2*FRAME_W +: 2*FRAME_W] !== '0) begin
         miscompares++;
         $display("FAIL partial_zero: got %h required 0", env_task_memory[2*FRAME_W +: 2*FRAME_W]);
      end
   endtask

   task automatic test_overflow();
      exp_q.push_back(model_bus(14, 32'h101, 32'h1));
      for (int k = 0; k < 14; k++) begin
         send_word(32'h101 + k, k == 13, 1'b0);
         if (k == 11 || k == 12) begin
            vectors++;
            if (err_overflow !== (k == 12)) begin
               miscompares++;
               $display("FAIL overflow_word%0d: err=%b required %b", k + 1, err_overflow, k == 12);
            end
         end
      end
      pulse_swap("overflow");
      send_word(32'h55, 1'b0, 1'b0);
      vectors++;
      if ({err_overflow, load_busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL overflow_clear: {err,busy}=%b required 01", {err_overflow, load_busy});
      end
      exp_q.push_back(model_bus(2, 32'h55, 32'h11));
      send_word(32'h66, 1'b1, 1'b0);
      pulse_swap("after_overflow");
   endtask

   task automatic test_coincident();
      exp_q.push_back(model_bus(3, 32'hA1, 32'h1));
      send_word(32'hA1, 1'b0, 1'b0);
      send_word(32'hA2, 1'b0, 1'b0);
      send_word(32'hA3, 1'b1, 1'b1);
      vectors++;
      if (swap_pending !== 1'b1 || env_task_memory !== cur_bus) begin
         miscompares++;
         $display("FAIL coincident: pend=%b bus=%h required 1/%h", swap_pending,
                  env_task_memory, cur_bus);
      end
      wr_valid = 1'b1; wr_data = 32'hDEAD;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (wr_ready !== 1'b0 || env_task_memory !== cur_bus) begin
            miscompares++;
            $display("FAIL pend_hold cycle %0d: rdy=%b bus=%h required 0/%h", i, wr_ready,
                     env_task_memory, cur_bus);
         end
      end
      wr_valid = 1'b0;
      pulse_swap("coincident");
   endtask

   task automatic test_reset_midload();
      load_program(5, 32'h201, 32'h1, 1'b0, 1'b0);
      vectors++;
      if (load_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midfill_busy: busy=%b required 1", load_busy);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (env_task_memory !== '0 ||
          {wr_ready, load_busy, swap_pending, prog_valid, err_overflow} !== 5'b10000) begin
         miscompares++;
         $display("FAIL midfill_reset: bus=%h status=%b required 0/10000", env_task_memory,
                  {wr_ready, load_busy, swap_pending, prog_valid, err_overflow});
      end
      exp_q.delete(); cur_bus = '0;
      @(posedge clk); #1 reset_n = 1'b1;
      load_program(2, 32'h301, 32'h1, 1'b1, 1'b1);
      pulse_swap("pre_pend_reset");
      load_program(3, 32'h401, 32'h1, 1'b1, 1'b0);
      vectors++;
      if (swap_pending !== 1'b1) begin
         miscompares++;
         $display("FAIL midpend_pend: pend=%b required 1", swap_pending);
      end
      #2 reset_n = 1'b0;
      #1;
      vectors++;
      if (env_task_memory !== '0 ||
          {wr_ready, load_busy, swap_pending, prog_valid, err_overflow} !== 5'b10000) begin
         miscompares++;
         $display("FAIL midpend_reset: bus=%h status=%b required 0/10000", env_task_memory,
                  {wr_ready, load_busy, swap_pending, prog_valid, err_overflow});
      end
      cur_bus = '0;
      @(posedge clk); #1 reset_n = 1'b1;
      load_program(2, 32'h77, 32'h11, 1'b1, 1'b1);
      pulse_swap("after_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_load();
      test_partial();
      test_overflow();
      test_coincident();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
